// File: rtl/bus_map_pkg.sv
// Address map shared by the data-bus responder and the CPU-side test programs.
// Every address is a byte address on the 10-bit data port; bits [1:0] never take part in decode.
package bus_map_pkg;

    localparam logic [9:0] RAM_TOP       = 10'h2FF;
    localparam logic [9:0] ADDR_CYCLE    = 10'h300;
    localparam logic [9:0] ADDR_CMP      = 10'h304;
    localparam logic [9:0] ADDR_STATUS   = 10'h308;
    localparam logic [9:0] ADDR_TXDATA   = 10'h30C;
    localparam logic [9:0] ADDR_FIFOSTAT = 10'h310;

    localparam int STATUS_TIMER_BIT = 0;
    localparam int STATUS_OVF_BIT   = 1;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_CYCLE,
        SEL_CMP,
        SEL_STATUS,
        SEL_TXDATA,
        SEL_FIFOSTAT,
        SEL_NONE
    } bus_sel_e;

    function automatic bus_sel_e decode_addr(input logic [9:0] addr);
        logic [9:0] a;
        a = addr & 10'h3FC;
        if (a <= RAM_TOP) return SEL_RAM;
        case (a)
            ADDR_CYCLE:    return SEL_CYCLE;
            ADDR_CMP:      return SEL_CMP;
            ADDR_STATUS:   return SEL_STATUS;
            ADDR_TXDATA:   return SEL_TXDATA;
            ADDR_FIFOSTAT: return SEL_FIFOSTAT;
            default:       return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO. A push into a full FIFO is still accepted when a pop
// frees a slot on the same edge; a pop on an empty FIFO is ignored.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[head_q];

    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_pop)  head_d = head_q + 1'b1;
        if (do_push) tail_d = tail_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !reset) mem_q[tail_q] <= din;
    end

endmodule

// File: rtl/data_bus_responder.sv
// Data-port responder for the single-cycle CPU: word RAM plus a peripheral window
// holding a cycle counter, a compare timer and an output FIFO. Reads are combinational.
module data_bus_responder
    import bus_map_pkg::*;
#(
    parameter int RAM_WORDS  = 192,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        regWE,
    input  logic [9:0]  DataAddr,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        timer_irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0] ram_q [RAM_WORDS];
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] cmp_q, cmp_d;
    logic        flag_q, flag_d;
    logic        ovf_q, ovf_d;

    bus_sel_e    sel;
    logic [7:0]  ram_idx;
    logic        ram_hit;
    logic        wr;
    logic        ram_we;
    logic        status_wr;
    logic        fifo_push, fifo_pop;
    logic        fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0] fifo_stat;

    assign sel     = decode_addr(DataAddr);
    assign ram_idx = DataAddr[9:2];
    assign ram_hit = (sel == SEL_RAM) && (int'(ram_idx) < RAM_WORDS);

    assign out_valid = !fifo_empty;
    assign timer_irq = flag_q;
    assign fifo_stat = {22'b0, fifo_empty, fifo_full, 8'(fifo_count)};

    always_comb begin
        wr        = regWE && !reset;
        ram_we    = wr && ram_hit;
        status_wr = wr && (sel == SEL_STATUS);
        fifo_push = wr && (sel == SEL_TXDATA);
        fifo_pop  = out_valid && out_ready;

        cycle_d = cycle_q + 32'd1;
        cmp_d   = cmp_q;
        if (wr && (sel == SEL_CMP)) cmp_d = DataIn;

        // Compare against the counter value that becomes visible after this edge,
        // so the flag and CYCLE==CMP appear together; a set beats a same-cycle clear.
        flag_d = (cycle_d == cmp_q) ||
                 (flag_q && !(status_wr && DataIn[STATUS_TIMER_BIT]));
        ovf_d  = (fifo_push && fifo_full && !fifo_pop) ||
                 (ovf_q && !(status_wr && DataIn[STATUS_OVF_BIT]));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q <= '0;
            cmp_q   <= '0;
            flag_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cycle_q <= cycle_d;
            cmp_q   <= cmp_d;
            flag_q  <= flag_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram_q[ram_idx] <= DataIn;
    end

    always_comb begin
        DataOut = '0;
        case (sel)
            SEL_RAM:      if (ram_hit) DataOut = ram_q[ram_idx];
            SEL_CYCLE:    DataOut = cycle_q;
            SEL_CMP:      DataOut = cmp_q;
            SEL_STATUS:   DataOut = {30'b0, ovf_q, flag_q};
            SEL_FIFOSTAT: DataOut = fifo_stat;
            default:      DataOut = '0;
        endcase
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_out_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (DataIn),
        .dout  (out_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: directed scenarios followed by random bus traffic,
// checked against a behavioural model; FIFO output words go through a scoreboard queue.
module tb_data_bus_responder;
    import bus_map_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        regWE = 1'b0;
    logic [9:0]  DataAddr = '0;
    logic [31:0] DataIn = '0;
    logic [31:0] DataOut;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        timer_irq;

    data_bus_responder #(.RAM_WORDS(192), .FIFO_DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .regWE     (regWE),
        .DataAddr  (DataAddr),
        .DataIn    (DataIn),
        .DataOut   (DataOut),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int pops = 0;

    // Behavioural model state
    logic [31:0] ram_m [192];
    bit          ram_v [192];
    logic [31:0] cycle_m, cmp_m;
    bit          flag_m, ovf_m;
    int          cnt_m;
    bit          model_ok = 1'b0;
    logic [31:0] sb [$];

    logic [31:0] last_dout;
    logic        last_valid, last_irq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [9:0] a);
        if (a <= RAM_TOP) return ram_m[a[9:2]];
        case (a)
            ADDR_CYCLE:    return cycle_m;
            ADDR_CMP:      return cmp_m;
            ADDR_STATUS:   return {30'b0, ovf_m, flag_m};
            ADDR_FIFOSTAT: return {22'b0, (cnt_m == 0), (cnt_m == 8), 8'(cnt_m)};
            default:       return 32'h0;
        endcase
    endfunction

    task automatic model_step(input bit rst, input bit we, input logic [9:0] a,
                              input logic [31:0] din, input bit rdy);
        bit pop, push, clr_t, clr_o, set_t, set_o;
        logic [31:0] nxt;
        if (rst) begin
            cycle_m = 0; cmp_m = 0; flag_m = 0; ovf_m = 0; cnt_m = 0;
            sb.delete();
            model_ok = 1'b1;
            return;
        end
        pop   = (cnt_m > 0) && rdy;
        push  = we && (a == ADDR_TXDATA);
        nxt   = cycle_m + 32'd1;
        set_t = (nxt == cmp_m);
        clr_t = we && (a == ADDR_STATUS) && din[0];
        clr_o = we && (a == ADDR_STATUS) && din[1];
        set_o = push && (cnt_m == 8) && !pop;
        flag_m = set_t || (flag_m && !clr_t);
        ovf_m  = set_o || (ovf_m && !clr_o);
        if (push && (cnt_m < 8 || pop)) begin
            sb.push_back(din);
            cnt_m++;
        end
        if (pop) cnt_m--;
        if (we && a == ADDR_CMP) cmp_m = din;
        if (we && a <= RAM_TOP) begin
            ram_m[a[9:2]] = din;
            ram_v[a[9:2]] = 1'b1;
        end
        cycle_m = nxt;
    endtask

    task automatic cycle(input bit rst, input bit we, input logic [9:0] addr,
                         input logic [31:0] din, input bit rdy);
        logic [9:0] a;
        @(posedge clk);
        #2;
        reset = rst; regWE = we; DataAddr = addr; DataIn = din; out_ready = rdy;
        #1;
        a = addr & 10'h3FC;
        last_dout  = DataOut;
        last_valid = out_valid;
        last_irq   = timer_irq;
        if (model_ok) begin
            if (!(a <= RAM_TOP && !ram_v[a[9:2]]))
                chk("dataout", DataOut, model_read(a));
            chk("out_valid", {31'b0, out_valid}, {31'b0, cnt_m > 0});
            chk("timer_irq", {31'b0, timer_irq}, {31'b0, flag_m});
        end
        model_step(rst, we, a, din, rdy);
    endtask

    // Scoreboard monitor: every accepted FIFO word must match the oldest expected word.
    initial begin
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            if (!reset && model_ok && out_valid && out_ready) begin
                pops++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_data_unexpected actual=%h expected=none", out_data);
                end else begin
                    exp = sb.pop_front();
                    chk("out_data", out_data, exp);
                end
            end
        end
    end

    initial begin
        int p0;
        logic [31:0] c;
        logic [9:0]  addr;
        int          idx;

        cycle(1, 0, 10'h0, 0, 0);
        cycle(1, 0, 10'h0, 0, 0);

        // RAM round trip and region boundaries
        cycle(0, 1, 10'h014, 32'hDEADBEEF, 0);
        cycle(0, 0, 10'h014, 0, 0);
        chk("ram_roundtrip", last_dout, 32'hDEADBEEF);
        cycle(0, 1, 10'h2FC, 32'h11111111, 0);
        cycle(0, 1, 10'h000, 32'h22222222, 0);
        cycle(0, 0, 10'h2FC, 0, 0);
        chk("ram_top_word", last_dout, 32'h11111111);
        cycle(0, 0, 10'h000, 0, 0);
        chk("ram_word0", last_dout, 32'h22222222);
        cycle(0, 1, 10'h3FC, 32'h12345678, 0);
        cycle(0, 0, 10'h3FC, 0, 0);
        chk("unmapped_read", last_dout, 32'h0);

        // Timer: CMP=20 written while CYCLE reads 0
        cycle(1, 0, 10'h0, 0, 0);
        cycle(0, 1, ADDR_CMP, 32'd20, 0);
        for (int i = 0; i < 22; i++) begin
            cycle(0, 0, ADDR_CYCLE, 0, 0);
            if (last_dout == 32'd19) chk("irq_before_cmp", {31'b0, last_irq}, 32'd0);
            if (last_dout == 32'd20) chk("irq_at_cmp", {31'b0, last_irq}, 32'd1);
        end
        cycle(0, 1, ADDR_STATUS, 32'h1, 0);
        cycle(0, 0, ADDR_STATUS, 0, 0);
        chk("flag_cleared", last_dout, 32'h0);
        chk("irq_cleared", {31'b0, last_irq}, 32'd0);
        c = cycle_m;
        cycle(0, 1, ADDR_CMP, c + 32'd3, 0);
        cycle(0, 0, ADDR_STATUS, 0, 0);
        cycle(0, 1, ADDR_STATUS, 32'h1, 0);
        cycle(0, 0, ADDR_STATUS, 0, 0);
        chk("set_beats_clear", last_dout, 32'h1);
        chk("irq_set_beats_clear", {31'b0, last_irq}, 32'd1);

        // FIFO fill and overflow
        cycle(1, 0, 10'h0, 0, 0);
        for (int v = 1; v <= 9; v++) cycle(0, 1, ADDR_TXDATA, v, 0);
        cycle(0, 0, ADDR_FIFOSTAT, 0, 0);
        chk("fifostat_full", last_dout, 32'h108);
        cycle(0, 0, ADDR_STATUS, 0, 0);
        chk("overflow_sticky", last_dout, 32'h2);
        chk("head_word", out_data, 32'd1);

        // Push while full and popping: accepted, no overflow
        cycle(0, 1, ADDR_STATUS, 32'h2, 0);
        cycle(0, 1, ADDR_TXDATA, 32'hA, 1);
        cycle(0, 0, ADDR_STATUS, 0, 0);
        chk("no_overflow_full_pushpop", last_dout, 32'h0);
        cycle(0, 0, ADDR_FIFOSTAT, 0, 0);
        chk("count_stays_8", last_dout, 32'h108);

        // Drain: one word per cycle
        p0 = pops;
        for (int i = 0; i < 8; i++) cycle(0, 0, ADDR_FIFOSTAT, 0, 1);
        cycle(0, 0, ADDR_FIFOSTAT, 0, 0);
        chk("fifostat_empty", last_dout, 32'h200);
        chk("drain_count", pops - p0, 32'd8);
        chk("valid_after_drain", {31'b0, last_valid}, 32'd0);

        // Push with ready on empty FIFO: stored, no pop
        cycle(0, 1, ADDR_TXDATA, 32'h55, 1);
        cycle(0, 0, ADDR_FIFOSTAT, 0, 0);
        chk("empty_pushpop_count", last_dout, 32'h001);

        // Reset mid-operation
        cycle(0, 1, ADDR_TXDATA, 32'h66, 0);
        cycle(0, 1, ADDR_TXDATA, 32'h77, 0);
        cycle(0, 1, ADDR_CMP, 32'd5, 0);
        cycle(1, 1, ADDR_TXDATA, 32'h99, 1);
        cycle(0, 0, ADDR_CYCLE, 0, 0);
        chk("cycle_restart", last_dout, 32'h0);
        chk("valid_after_reset", {31'b0, last_valid}, 32'd0);
        cycle(0, 0, ADDR_CMP, 0, 0);
        chk("cmp_after_reset", last_dout, 32'h0);
        cycle(0, 0, 10'h014, 0, 0);
        chk("ram_survives_reset", last_dout, 32'hDEADBEEF);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            int op;
            bit rdy, we, rst;
            logic [31:0] d;
            op  = $urandom_range(0, 9);
            rdy = ($urandom_range(0, 2) != 0);
            d   = $urandom;
            we  = 1'b0;
            rst = 1'b0;
            idx = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 15) : $urandom_range(176, 191);
            addr = 10'(idx * 4 + $urandom_range(0, 3));
            case (op)
                0, 1: we = 1'b1;
                2:    we = 1'b0;
                3: begin addr = ADDR_CMP; we = 1'b1; d = cycle_m + $urandom_range(1, 12); end
                4: begin addr = ADDR_STATUS; we = 1'b1; d = 32'($urandom_range(0, 3)); end
                5, 6: begin addr = ADDR_TXDATA; we = 1'b1; end
                7: begin addr = 10'(32'h300 + 4 * $urandom_range(0, 63)); we = ($urandom_range(0, 1) != 0); end
                8: begin addr = ADDR_FIFOSTAT; rst = ($urandom_range(0, 49) == 0); end
                default: addr = ADDR_STATUS;
            endcase
            cycle(rst, we, addr, d, rdy);
        end

        cycle(0, 0, ADDR_STATUS, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
